mem_stage_lsu: RTL and testbench

//  RV32 memory stage with internal data RAM and MEM/WB pipeline register.

---
 rtl/mem_stage_lsu_if.sv | 41 ++++
 rtl/mem_stage_lsu.sv | 167 ++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/mem_stage_lsu_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu_if
// Description : M-side request and W-side result bundle of the memory stage.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_stage_lsu_if;
   logic        FlushM;
   logic        RegWriteM;
   logic        MemWriteM;
   logic        MemReadM;
   logic [1:0]  ResultSrcM;
   logic [2:0]  Funct3M;
   logic [31:0] ALU_ResultM;
   logic [31:0] WriteDataM;
   logic [4:0]  RD_M;
   logic [31:0] PCPlus4M;
   logic        StallM;
   logic        RegWriteW;
   logic [1:0]  ResultSrcW;
   logic [4:0]  RD_W;
   logic [31:0] PCPlus4W;
   logic [31:0] ReadDataW;
   logic [31:0] ALU_ResultW;
   logic        ExcW;

   modport master (
      output FlushM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M,
             ALU_ResultM, WriteDataM, RD_M, PCPlus4M,
      input  StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ReadDataW,
             ALU_ResultW, ExcW
   );

   modport slave (
      input  FlushM, RegWriteM, MemWriteM, MemReadM, ResultSrcM, Funct3M,
             ALU_ResultM, WriteDataM, RD_M, PCPlus4M,
      output StallM, RegWriteW, ResultSrcW, RD_W, PCPlus4W, ReadDataW,
             ALU_ResultW, ExcW
   );
endinterface
`default_nettype wire

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : mem_stage_lsu
// Description : RV32 memory stage: data RAM, sub-word access, wait states,
//               MEM/WB pipeline register.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
   parameter int ADDR_W      = 10,
   parameter int WAIT_STATES = 0
) (
   input wire             clk,
   input wire             rst,
   mem_stage_lsu_if.slave bus
);
   typedef enum logic [0:0] {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

   localparam logic [3:0] c_waitStates = 4'(WAIT_STATES);
   localparam int         c_depth      = 1 << ADDR_W;

   logic [31:0]       r_mem [0:c_depth-1];
   state_t            r_state;
   logic [3:0]        r_cnt;

   logic              w_access, w_misalign, w_illegal, w_exc;
   logic              w_stall, w_final, w_memWe;
   logic [ADDR_W-1:0] w_idx;
   logic [1:0]        w_byteOff;
   logic [31:0]       w_rdWord, w_loadData, w_wrData;
   logic [3:0]        w_byteEn;
   logic [7:0]        w_byte;
   logic [15:0]       w_half;

   assign w_idx     = bus.ALU_ResultM[ADDR_W+1:2];
   assign w_byteOff = bus.ALU_ResultM[1:0];
   assign w_access  = (bus.MemReadM | bus.MemWriteM) & ~bus.FlushM;

   always_comb begin
      w_misalign = 1'b0;
      w_illegal  = 1'b0;
      case (bus.Funct3M)
         3'b000, 3'b100: w_misalign = 1'b0;
         3'b001, 3'b101: w_misalign = w_byteOff[0];
         3'b010:         w_misalign = (w_byteOff != 2'b00);
         default:        w_illegal  = 1'b1;
      endcase
   end

   assign w_exc = w_access & (w_misalign | w_illegal);

   // In WAIT the counter runs 1..WAIT_STATES; the access completes when it reaches the limit.
   always_comb begin
      w_stall = 1'b0;
      if (w_access && !w_exc) begin
         if (r_state == S_IDLE) w_stall = (c_waitStates != 4'd0);
         else                   w_stall = (r_cnt != c_waitStates);
      end
   end

   assign w_final = w_access & ~w_exc & ~w_stall;
   assign w_memWe = w_final & bus.MemWriteM & ~rst;

   always_comb begin
      w_byteEn = 4'b1111;
      w_wrData = bus.WriteDataM;
      case (bus.Funct3M[1:0])
         2'b00: begin
            w_byteEn = 4'b0001 << w_byteOff;
            w_wrData = {4{bus.WriteDataM[7:0]}};
         end
         2'b01: begin
            w_byteEn = w_byteOff[1] ? 4'b1100 : 4'b0011;
            w_wrData = {2{bus.WriteDataM[15:0]}};
         end
         default: begin
            w_byteEn = 4'b1111;
            w_wrData = bus.WriteDataM;
         end
      endcase
   end

   assign w_rdWord = r_mem[w_idx];
   assign w_byte   = w_rdWord[{w_byteOff, 3'b000} +: 8];
   assign w_half   = w_byteOff[1] ? w_rdWord[31:16] : w_rdWord[15:0];

   always_comb begin
      w_loadData = '0;
      case (bus.Funct3M)
         3'b000:  w_loadData = {{24{w_byte[7]}}, w_byte};
         3'b001:  w_loadData = {{16{w_half[15]}}, w_half};
         3'b010:  w_loadData = w_rdWord;
         3'b100:  w_loadData = {24'd0, w_byte};
         3'b101:  w_loadData = {16'd0, w_half};
         default: w_loadData = '0;
      endcase
   end

   assign bus.StallM = w_stall;

   always_ff @(posedge clk) begin
      if (w_memWe) begin
         for (int b = 0; b < 4; b++) begin
            if (w_byteEn[b]) r_mem[w_idx][8*b +: 8] <= w_wrData[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state         <= S_IDLE;
         r_cnt           <= '0;
         bus.RegWriteW   <= 1'b0;
         bus.ResultSrcW  <= '0;
         bus.RD_W        <= '0;
         bus.PCPlus4W    <= '0;
         bus.ReadDataW   <= '0;
         bus.ALU_ResultW <= '0;
         bus.ExcW        <= 1'b0;
      end else begin
         if (bus.FlushM) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
         end else begin
            case (r_state)
               S_IDLE: begin
                  if (w_stall) begin
                     r_state <= S_WAIT;
                     r_cnt   <= 4'd1;
                  end
               end
               S_WAIT: begin
                  if (w_stall) begin
                     r_cnt <= r_cnt + 4'd1;
                  end else begin
                     r_state <= S_IDLE;
                     r_cnt   <= '0;
                  end
               end
               default: begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
               end
            endcase
         end

         // Flushed or still-waiting instructions leave a bubble in W.
         if (bus.FlushM || w_stall) begin
            bus.RegWriteW   <= 1'b0;
            bus.ResultSrcW  <= '0;
            bus.RD_W        <= '0;
            bus.PCPlus4W    <= '0;
            bus.ReadDataW   <= '0;
            bus.ALU_ResultW <= '0;
            bus.ExcW        <= 1'b0;
         end else begin
            bus.RegWriteW   <= bus.RegWriteM & ~w_exc;
            bus.ResultSrcW  <= bus.ResultSrcM;
            bus.RD_W        <= bus.RD_M;
            bus.PCPlus4W    <= bus.PCPlus4M;
            bus.ReadDataW   <= (bus.MemReadM && !w_exc) ? w_loadData : '0;
            bus.ALU_ResultW <= bus.ALU_ResultM;
            bus.ExcW        <= w_exc;
         end
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_stage_lsu
// Description : Self-checking bench for mem_stage_lsu (0 and 3 wait states).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;
   typedef struct packed {
      logic        regW;
      logic [1:0]  rs;
      logic [4:0]  rd;
      logic [31:0] pc4;
      logic [31:0] data;
      logic [31:0] alu;
      logic        exc;
   } wexp_t;

   typedef struct {
      string       name;
      logic [3:0]  ctl;      // {flush, regWrite, memWrite, memRead}
      logic [2:0]  f3;
      logic [31:0] addr;
      logic [31:0] wd;
      logic [31:0] expData;
      logic        expExc;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic        flushM = 1'b0, regWriteM = 1'b0, memWriteM = 1'b0, memReadM = 1'b0;
   logic [1:0]  resultSrcM = '0;
   logic [2:0]  funct3M = '0;
   logic [31:0] aluResultM = '0, writeDataM = '0, pcPlus4M = '0;
   logic [4:0]  rdM = '0;

   int tests = 0;
   int fails = 0;
   int seq   = 0;
   wexp_t q[$];
   vec_t  vecs[$];
   localparam wexp_t BUBBLE = '0;

   mem_stage_lsu_if if0 ();
   mem_stage_lsu_if if3 ();

   assign if0.FlushM = flushM;       assign if3.FlushM = flushM;
   assign if0.RegWriteM = regWriteM; assign if3.RegWriteM = regWriteM;
   assign if0.MemWriteM = memWriteM; assign if3.MemWriteM = memWriteM;
   assign if0.MemReadM = memReadM;   assign if3.MemReadM = memReadM;
   assign if0.ResultSrcM = resultSrcM; assign if3.ResultSrcM = resultSrcM;
   assign if0.Funct3M = funct3M;     assign if3.Funct3M = funct3M;
   assign if0.ALU_ResultM = aluResultM; assign if3.ALU_ResultM = aluResultM;
   assign if0.WriteDataM = writeDataM;  assign if3.WriteDataM = writeDataM;
   assign if0.RD_M = rdM;            assign if3.RD_M = rdM;
   assign if0.PCPlus4M = pcPlus4M;   assign if3.PCPlus4M = pcPlus4M;

   mem_stage_lsu #(.ADDR_W(10), .WAIT_STATES(0)) u_dut0 (.clk(clk), .rst(rst), .bus(if0.slave));
   mem_stage_lsu #(.ADDR_W(10), .WAIT_STATES(3)) u_dut3 (.clk(clk), .rst(rst), .bus(if3.slave));

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string name, input logic [104:0] got, input logic [104:0] exp);
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s got=%h exp=%h", name, got, exp);
      end
   endtask

   function automatic wexp_t getW0();
      return {if0.RegWriteW, if0.ResultSrcW, if0.RD_W, if0.PCPlus4W,
              if0.ReadDataW, if0.ALU_ResultW, if0.ExcW};
   endfunction

   function automatic wexp_t getW3();
      return {if3.RegWriteW, if3.ResultSrcW, if3.RD_W, if3.PCPlus4W,
              if3.ReadDataW, if3.ALU_ResultW, if3.ExcW};
   endfunction

   // Reference for what W should hold once the currently driven instruction retires.
   function automatic wexp_t mkExp(input logic [31:0] d, input logic e);
      wexp_t w = '0;
      if (!flushM) w = {regWriteM & ~e, resultSrcM, rdM, pcPlus4M, d, aluResultM, e};
      return w;
   endfunction

   task automatic setM(input logic [3:0] ctl, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wd);
      seq++;
      {flushM, regWriteM, memWriteM, memReadM} = ctl;
      funct3M    = f3;
      aluResultM = addr;
      writeDataM = wd;
      rdM        = 5'(seq);
      resultSrcM = 2'(seq);
      pcPlus4M   = 32'h1000 + 32'(seq * 4);
   endtask

   // Runs one held instruction on the 3-wait-state DUT, checking bubbles and final result.
   task automatic run3(input string name, input logic [31:0] expData,
                       input logic expExc, input int expStalls);
      int    stalls = 0;
      bit    done   = 0;
      wexp_t got;
      q.push_back(mkExp(expData, expExc));
      for (int c = 0; c < 16 && !done; c++) begin
         @(negedge clk);
         if (if3.StallM) begin
            stalls++;
            @(posedge clk); #1;
            got = getW3();
            chk({name, "_bubble"}, got, BUBBLE);
         end else begin
            @(posedge clk); #1;
            got = getW3();
            chk(name, got, q.pop_front());
            done = 1;
         end
      end
      if (!done) begin
         tests++; fails++;
         $display("FAIL %s_timeout got=no_completion exp=completion", name);
      end
      chk({name, "_stalls"}, 105'(stalls), 105'(expStalls));
   endtask

   initial begin
      wexp_t got;
      vecs.push_back('{"sw10",     4'b0010, 3'b010, 32'h10,   32'hDEADBEEF, 32'h0,        1'b0});
      vecs.push_back('{"lw10",     4'b0101, 3'b010, 32'h10,   32'h0,        32'hDEADBEEF, 1'b0});
      vecs.push_back('{"sb13",     4'b0010, 3'b000, 32'h13,   32'h80,       32'h0,        1'b0});
      vecs.push_back('{"lb13",     4'b0101, 3'b000, 32'h13,   32'h0,        32'hFFFFFF80, 1'b0});
      vecs.push_back('{"lbu13",    4'b0101, 3'b100, 32'h13,   32'h0,        32'h00000080, 1'b0});
      vecs.push_back('{"lw10_sb",  4'b0101, 3'b010, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0});
      vecs.push_back('{"lh11_exc", 4'b0101, 3'b001, 32'h11,   32'h0,        32'h0,        1'b1});
      vecs.push_back('{"sw12_exc", 4'b0010, 3'b010, 32'h12,   32'h12345678, 32'h0,        1'b1});
      vecs.push_back('{"lw10_nowr",4'b0101, 3'b010, 32'h10,   32'h0,        32'h80ADBEEF, 1'b0});
      vecs.push_back('{"sh12",     4'b0010, 3'b001, 32'h12,   32'hFFFFCAFE, 32'h0,        1'b0});
      vecs.push_back('{"lh12",     4'b0101, 3'b001, 32'h12,   32'h0,        32'hFFFFCAFE, 1'b0});
      vecs.push_back('{"lhu10",    4'b0101, 3'b101, 32'h10,   32'h0,        32'h0000BEEF, 1'b0});
      vecs.push_back('{"lb10",     4'b0101, 3'b000, 32'h10,   32'h0,        32'hFFFFFFEF, 1'b0});
      vecs.push_back('{"ill011",   4'b0101, 3'b011, 32'h10,   32'h0,        32'h0,        1'b1});
      vecs.push_back('{"alu_op",   4'b0100, 3'b111, 32'h55,   32'h0,        32'h0,        1'b0});
      vecs.push_back('{"sw_alias", 4'b0010, 3'b010, 32'h1008, 32'h11223344, 32'h0,        1'b0});
      vecs.push_back('{"lw08",     4'b0101, 3'b010, 32'h8,    32'h0,        32'h11223344, 1'b0});
      vecs.push_back('{"lb1009",   4'b0101, 3'b000, 32'h1009, 32'h0,        32'h00000033, 1'b0});
      vecs.push_back('{"flush_sw", 4'b1010, 3'b010, 32'h10,   32'h0,        32'h0,        1'b0});
      vecs.push_back('{"lw10_end", 4'b0101, 3'b010, 32'h10,   32'h0,        32'hCAFEBEEF, 1'b0});

      repeat (2) @(posedge clk);
      #1;
      chk("reset_w0", getW0(), BUBBLE);
      chk("reset_w3", getW3(), BUBBLE);
      chk("reset_stall", {if0.StallM, if3.StallM}, '0);
      rst = 1'b0;

      // Single-cycle DUT: every vector retires on the next edge.
      foreach (vecs[i]) begin
         setM(vecs[i].ctl, vecs[i].f3, vecs[i].addr, vecs[i].wd);
         q.push_back(mkExp(vecs[i].expData, vecs[i].expExc));
         @(negedge clk);
         chk({vecs[i].name, "_stall"}, 105'(if0.StallM), '0);
         @(posedge clk); #1;
         got = getW0();
         chk(vecs[i].name, got, q.pop_front());
      end

      setM(4'b0000, 3'b000, 32'h0, 32'h0);
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;

      setM(4'b0010, 3'b010, 32'h20, 32'hA5A5A5A5);
      run3("sw20_ws3", 32'h0, 1'b0, 3);
      setM(4'b0101, 3'b010, 32'h20, 32'h0);
      run3("lw20_ws3", 32'hA5A5A5A5, 1'b0, 3);
      setM(4'b0101, 3'b001, 32'h21, 32'h0);
      run3("lh21_exc_ws3", 32'h0, 1'b1, 0);

      // Flush on the second cycle of a waiting load.
      setM(4'b0101, 3'b010, 32'h20, 32'h0);
      @(negedge clk);
      chk("flush_c1_stall", 105'(if3.StallM), 105'(1));
      @(posedge clk); #1;
      chk("flush_c1_w", getW3(), BUBBLE);
      flushM = 1'b1;
      @(negedge clk);
      chk("flush_c2_stall", 105'(if3.StallM), '0);
      @(posedge clk); #1;
      chk("flush_c2_w", getW3(), BUBBLE);
      flushM = 1'b0;
      run3("lw_after_flush", 32'hA5A5A5A5, 1'b0, 3);

      setM(4'b0100, 3'b000, 32'h77, 32'h0);
      run3("alu_ws3", 32'h0, 1'b0, 0);

      // Reset in the middle of a waiting store: no write, FSM back to IDLE.
      setM(4'b0010, 3'b010, 32'h20, 32'h0BADF00D);
      @(negedge clk);
      chk("rst_c1_stall", 105'(if3.StallM), 105'(1));
      @(posedge clk); #1;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      chk("rst_midwait_w", getW3(), BUBBLE);
      setM(4'b0101, 3'b010, 32'h20, 32'h0);
      run3("lw_after_rst", 32'hA5A5A5A5, 1'b0, 3);

      setM(4'b0000, 3'b000, 32'h0, 32'h0);
      @(posedge clk); #1;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
`default_nettype wire
